// File: rtl/prod_bcd_disp.sv
// prod_bcd_disp: captures the multiplier's 6-bit product on a load strobe and
// converts it to two BCD digits with a sequential shift-add-3 engine. It drives
// a time-multiplexed, active-low, 2-digit 7-segment display from the last
// converted value.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   z     - 6-bit unsigned product (0..63)
//   load  - start conversion, accepted in IDLE or DONE
//   busy  - conversion in progress
//   done  - one-cycle pulse when bcd is updated
//   bcd   - {tens, ones} of the last accepted z
//   seg   - {g,f,e,d,c,b,a}, active-low
//   an    - digit enables, active-low; an[0] = ones, an[1] = tens
//
// Optional feature: define LEAD_ZERO_BLANK_EN to blank a zero tens digit.
module prod_bcd_disp #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] z,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [13:0]     sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      bcd_q, bcd_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic            sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM
  always_comb begin
    logic [13:0] adj;
    logic [13:0] shifted;
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    adj     = sr_q;
    shifted = '0;
    if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
    if (adj[9:6]   >= 4'd5) adj[9:6]   = adj[9:6]   + 4'd3;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          sr_d    = {8'h00, z};
          cnt_d   = '0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        shifted = {adj[12:0], 1'b0};
        sr_d    = shifted;
        cnt_d   = cnt_q + 3'd1;
        // cnt_q == 5 is the sixth iteration; publish its shifted result now
        if (cnt_q == 3'd5) begin
          bcd_d   = shifted[13:6];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display scan; seg/an follow sel_q and bcd_q one edge later
  always_comb begin
    logic [3:0] digit;
    scan_d = scan_q + CW'(1);
    sel_d  = sel_q;
    if (scan_q == CW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
    digit = sel_q ? bcd_q[7:4] : bcd_q[3:0];
    seg_d = decode(digit);
    an_d  = sel_q ? 2'b01 : 2'b10;
`ifdef LEAD_ZERO_BLANK_EN
    if (sel_q && (bcd_q[7:4] == 4'd0)) seg_d = 7'b1111111;
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
      seg_q   <= 7'b1000000;
      an_q    <= 2'b10;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q == S_CONV);
  assign done = (state_q == S_DONE);
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_prod_bcd_disp.sv
module tb_prod_bcd_disp;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] z;
  logic       load;
  logic       busy, done;
  logic [7:0] bcd;
  logic [6:0] seg;
  logic [1:0] an;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  prod_bcd_disp #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .z(z), .load(load), .busy(busy), .done(done),
    .bcd(bcd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each done pulse pops one expected bcd
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got bcd %0h expected no done", bcd);
      end else begin
        check("sb_bcd", bcd, exp_q.pop_front());
      end
    end
  end

  // Drives load for edge N and returns #1 after it with load low
  task automatic drive_load(input logic [5:0] val, input bit push);
    @(negedge clk);
    z = val;
    load = 1'b1;
    if (push) exp_q.push_back({4'(val / 10), 4'(val % 10)});
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(posedge clk); #1;
    while ((busy || done) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 30) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  // Waits (bounded) until the given digit is selected, then checks seg
  task automatic check_digit(input string name, input logic [1:0] want_an, input logic [6:0] want_seg);
    int k = 0;
    while (an !== want_an && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_an"}, an, want_an);
    check({name, "_seg"}, seg, want_seg);
  endtask

  initial begin
    int d0;
    int run;
    logic [1:0] prev_an;
    bit first_run;
    rst = 1'b1; load = 1'b0; z = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 8'h00);
    check("rst_an", an, 2'b10);
    check("rst_seg", seg, 7'b1000000);
    @(negedge clk) rst = 1'b0;

    // z=49 latency and pulse timing
    drive_load(6'd49, 1);
    check("t49_busy_N", busy, 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k < 6) begin
        check("t49_busy_mid", busy, 1);
        check("t49_done_mid", done, 0);
      end else begin
        check("t49_busy_N6", busy, 0);
        check("t49_done_N6", done, 1);
        check("t49_bcd_N6", bcd, 8'h49);
      end
    end
    @(posedge clk); #1;
    check("t49_done_N7", done, 0);

    // z=0: tens digit shows zero or blanks
    drive_load(6'd0, 1);
    wait_idle();
    check("z0_bcd", bcd, 8'h00);
    check_digit("z0_ones", 2'b10, 7'b1000000);
`ifdef LEAD_ZERO_BLANK_EN
    check_digit("z0_tens", 2'b01, 7'b1111111);
`else
    check_digit("z0_tens", 2'b01, 7'b1000000);
`endif

    // z=63
    drive_load(6'd63, 1);
    wait_idle();
    check("z63_bcd", bcd, 8'h63);
    check_digit("z63_tens", 2'b01, 7'b0000010);
    check_digit("z63_ones", 2'b10, 7'b0110000);

    // Exhaustive sweep
    for (int v = 0; v < 64; v++) begin
      drive_load(6'(v), 1);
      wait_idle();
    end

    // Load during CONV is ignored
    d0 = done_cnt;
    drive_load(6'd12, 1);
    @(posedge clk);
    drive_load(6'd35, 0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("ign_bcd", bcd, 8'h12);
    check("ign_done_cnt", done_cnt - d0, 1);

    // Back-to-back: load held, z changes after the accepting edge
    d0 = done_cnt;
    @(negedge clk);
    z = 6'd8; load = 1'b1;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h09);
    @(posedge clk);
    #1 z = 6'd9;
    repeat (7) @(posedge clk);
    #1;
    check("b2b_busy_N7", busy, 1);
    load = 1'b0;
    wait_idle();
    check("b2b_bcd", bcd, 8'h09);
    check("b2b_done_cnt", done_cnt - d0, 2);

    // Reset mid-conversion aborts
    d0 = done_cnt;
    drive_load(6'd27, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 8'h00);
    check("abort_an", an, 2'b10);
    check("abort_seg", seg, 7'b1000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_bcd_after", bcd, 8'h00);

    // Scan: bcd=27, SCAN_DIV=4
    drive_load(6'd27, 1);
    wait_idle();
    @(posedge clk); #1;
    prev_an = an;
    run = 0;
    first_run = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (an == 2'b10) check("scan_seg_ones", seg, 7'b1111000);
      else begin
        check("scan_an_legal", an, 2'b01);
        check("scan_seg_tens", seg, 7'b0100100);
      end
      run++;
      @(posedge clk); #1;
      if (an !== prev_an) begin
        if (!first_run) check("scan_period", run, 4);
        first_run = 1'b0;
        run = 0;
        prev_an = an;
      end
    end
    check("scan_toggled", first_run, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prod_bcd_disp.md
# prod_bcd_disp

Downstream display stage for the 3-bit multiplier's 6-bit product. On a load strobe it captures the product and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed 2-digit, active-low 7-segment display on the board. The block holds the last converted value and keeps scanning until a new load is accepted.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit-scan slot; legal range ≥2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `z`  in  6  unsigned product from the multiplier, range 0..63.
- `load`  in  1  start conversion; sampled only when idle.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd` is updated.
- `bcd`  out  8  {tens, ones} BCD of the last accepted `z`.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low segment drive.
- `an`  out  2  digit enables, active-low; `an[0]` = ones, `an[1]` = tens.

## Operation
- Reset values: `busy`=0, `done`=0, `bcd`=8'h00, scan select=ones, `an`=2'b10, `seg`=7'b1000000 (digit 0). The scan counter is also reset to 0.
- The FSM has three states: IDLE, CONV and DONE. DONE behaves as IDLE for `load` acceptance.
- IDLE/DONE with `load`=1: capture `z` into a 14-bit shift register {tens[3:0], ones[3:0], bin[5:0]} with BCD nibbles cleared. Set iteration count to 0 and go to CONV.
- Each CONV cycle does two things in one clock: first, add 3 to every BCD nibble that is ≥5; then shift the whole register left by 1. The count increments.
- After the 6th iteration: latch the BCD nibbles into `bcd` and go to DONE.
- DONE lasts exactly one cycle with `done`=1, then moves to IDLE unless `load`=1 (new capture).
- `load` in CONV is ignored and not queued.
- `z` is sampled only on the accepting edge; later changes do not affect the conversion.
- The tens nibble never exceeds 6 and the ones nibble never exceeds 9. The hundreds digit is not needed.
- Display scan:
  - A free-running counter counts 0..SCAN_DIV-1. On wrap, the digit select toggles.
  - Select=ones: `an`=2'b10, `seg`=decode(`bcd[3:0]`).
  - Select=tens: `an`=2'b01, `seg`=decode(`bcd[7:4]`), subject to Configuration.
- Decode (active-low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Any other code→1111111.
- `seg` and `an` are registered; they change together on the edge after a select toggle or a `bcd` update.

## Timing
- `load` is sampled at edge N. `busy`=1 from after edge N through edge N+6.
- At edge N+6, `bcd` takes the new value, `busy`→0 and `done`→1. `done` falls at edge N+7.
- Latency from `load` to `bcd` is 6 cycles. Maximum accept rate is one conversion per 7 cycles. Back-to-back operation is legal: `load` held high in DONE restarts at N+7.
- Display update lag: `seg` reflects a new `bcd` no later than 1 cycle after `done` for the currently selected digit.
- Asynchronous `rst` mid-conversion aborts immediately. All outputs return to their reset values and the partial result is discarded.
- Release of `rst` is synchronous to `clk` by the board; first `load` is accepted at the first edge after release.

## Configuration
- `LEAD_ZERO_BLANK_EN` defined: when select=tens and `bcd[7:4]`==0, `seg`=7'b1111111 (tens blank). `an` still scans normally.
- Not defined: the tens digit always shows its decoded value, including 0.
- Macro has no effect on the ones digit, `bcd`, `busy`, `done` or conversion timing.

## Test plan
- `z`=49, `load` pulse at edge N → `busy` high 6 cycles, `bcd`=8'h49 and `done`=1 exactly at edge N+6, `done`=0 at N+7.
- `z`=0 and `z`=63 → `bcd`=8'h00 and 8'h63 respectively. With `LEAD_ZERO_BLANK_EN`, 8'h00 shows tens `seg`=1111111; without it, tens `seg`=1000000.
- Exhaustive check, z=0..63 → `bcd` = {z/10, z%10} for every value, with no illegal nibbles.
- `load` with `z`=12, then `load` with `z`=35 two cycles later (during CONV) → second load ignored, `bcd`=8'h12, single `done` pulse.
- `z`=27 load, assert `rst` at edge N+3 → `busy`=0, `bcd`=8'h00, `an`=2'b10, no `done` pulse.
- `SCAN_DIV`=4, `bcd`=8'h27 → `an` alternates 10/01 every 4 cycles. `seg`=1111000 while ones is active and `seg`=0100100 while tens is active.
